// File: rtl/wb_line_narrower_if.sv
// Classic Wishbone bus bundle with master/slave views; widths set per instance so the
// same definition serves both the line-wide and the narrow memory side.
interface wb_line_narrower_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = 4
) ();
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat_w;  // master -> slave
    logic [DATA_WIDTH-1:0] dat_r;  // slave -> master
    logic                  we;
    logic [SEL_WIDTH-1:0]  sel;
    logic                  stb;
    logic                  cyc;
    logic                  ack;
    logic                  err;
    logic                  rty;

    modport master (
        output adr, dat_w, we, sel, stb, cyc,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, we, sel, stb, cyc,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/wb_line_narrower.sv
// Splits one line-wide Wishbone request into ascending narrow single beats, skipping
// beats with an all-zero byte-select slice, and returns a single ack/err on the line side.
module wb_line_narrower #(
    parameter int unsigned LINE_WIDTH       = 128,
    parameter int unsigned NARROW_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned ADDR_GRANULARITY = 8
) (
    input  logic               clk,
    input  logic               rst,
    wb_line_narrower_if.slave  wbs,
    wb_line_narrower_if.master wbm
);
    localparam int unsigned Beats     = LINE_WIDTH / NARROW_WIDTH;
    localparam int unsigned BeatW     = $clog2(Beats);
    localparam int unsigned LineSel   = LINE_WIDTH / ADDR_GRANULARITY;
    localparam int unsigned NarrowSel = NARROW_WIDTH / ADDR_GRANULARITY;

    typedef enum logic [1:0] {StIdle, StBeat, StResp} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [LINE_WIDTH-1:0]   dat_q, dat_d;
    logic [LineSel-1:0]      sel_q, sel_d;
    logic                    we_q, we_d;
    logic [BeatW-1:0]        beat_q, beat_d;
    logic [LINE_WIDTH-1:0]   asm_q, asm_d;
    logic [ADDR_WIDTH-1:0]   madr_q, madr_d;
    logic [NarrowSel-1:0]    msel_q, msel_d;
    logic [NARROW_WIDTH-1:0] mdat_q, mdat_d;
    logic                    mwe_q, mwe_d;
    logic                    mstb_q, mstb_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;

    logic                    load, drop;
    logic [BeatW:0]          hit;
    logic [ADDR_WIDTH-1:0]   src_base;
    logic [LINE_WIDTH-1:0]   src_dat;
    logic [LineSel-1:0]      src_sel;
    logic                    src_we;

    // Lowest beat index >= from whose select slice is nonzero; MSB flags a hit.
    function automatic logic [BeatW:0] find_beat(input logic [LineSel-1:0] sel,
                                                 input int unsigned from);
        logic [BeatW:0] res;
        res = '0;
        for (int b = int'(Beats) - 1; b >= 0; b--) begin
            if (b >= int'(from) && |sel[b*NarrowSel +: NarrowSel]) begin
                res = {1'b1, BeatW'(b)};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        beat_d   = beat_q;
        asm_d    = asm_q;
        madr_d   = madr_q;
        msel_d   = msel_q;
        mdat_d   = mdat_q;
        mwe_d    = mwe_q;
        mstb_d   = mstb_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        load     = 1'b0;
        drop     = 1'b0;
        hit      = '0;
        src_base = base_q;
        src_dat  = dat_q;
        src_sel  = sel_q;
        src_we   = we_q;

        unique case (state_q)
            StIdle: begin
                if (wbs.cyc && wbs.stb) begin
                    base_d   = wbs.adr & ~ADDR_WIDTH'(LineSel - 1);
                    dat_d    = wbs.dat_w;
                    sel_d    = wbs.sel;
                    we_d     = wbs.we;
                    asm_d    = '0;
                    src_base = base_d;
                    src_dat  = wbs.dat_w;
                    src_sel  = wbs.sel;
                    src_we   = wbs.we;
                    hit      = find_beat(wbs.sel, 0);
                    if (hit[BeatW]) begin
                        state_d = StBeat;
                        load    = 1'b1;
                    end else begin
                        state_d = StResp;
                        ack_d   = 1'b1;
                    end
                end
            end
            StBeat: begin
                if (!wbs.cyc) begin
                    state_d = StIdle;
                    drop    = 1'b1;
                end else if (wbm.err) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    drop    = 1'b1;
                end else if (wbm.ack) begin
                    if (!we_q) begin
                        asm_d[beat_q*NARROW_WIDTH +: NARROW_WIDTH] = wbm.dat_r;
                    end
                    hit = find_beat(sel_q, 32'(beat_q) + 32'd1);
                    if (hit[BeatW]) begin
                        load = 1'b1;
                    end else begin
                        state_d = StResp;
                        ack_d   = 1'b1;
                        drop    = 1'b1;
                    end
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (load) begin
            beat_d = hit[BeatW-1:0];
            madr_d = src_base + ADDR_WIDTH'(beat_d) * ADDR_WIDTH'(NarrowSel);
            msel_d = src_sel[beat_d*NarrowSel +: NarrowSel];
            mdat_d = src_dat[beat_d*NARROW_WIDTH +: NARROW_WIDTH];
            mwe_d  = src_we;
            mstb_d = 1'b1;
        end else if (drop) begin
            madr_d = '0;
            msel_d = '0;
            mdat_d = '0;
            mwe_d  = 1'b0;
            mstb_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            beat_q  <= '0;
            asm_q   <= '0;
            madr_q  <= '0;
            msel_q  <= '0;
            mdat_q  <= '0;
            mwe_q   <= 1'b0;
            mstb_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
            madr_q  <= madr_d;
            msel_q  <= msel_d;
            mdat_q  <= mdat_d;
            mwe_q   <= mwe_d;
            mstb_q  <= mstb_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign wbs.dat_r = asm_q;
    assign wbs.ack   = ack_q;
    assign wbs.err   = err_q;
    assign wbs.rty   = 1'b0;

    assign wbm.adr   = madr_q;
    assign wbm.sel   = msel_q;
    assign wbm.dat_w = mdat_q;
    assign wbm.we    = mwe_q;
    assign wbm.stb   = mstb_q;
    assign wbm.cyc   = mstb_q;

    // The narrow bus never retries.
    logic unused_rty;
    assign unused_rty = wbm.rty;
endmodule

// File: tb/tb_wb_line_narrower.sv
// Bench for wb_line_narrower: directed vector table, hand-written abort/reset sequences
// and randomized lines scored against a beat-list model of the adapter.
module tb_wb_line_narrower;
    typedef struct packed {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        we;
    } beat_t;

    typedef struct {
        logic         we;
        logic [31:0]  adr;
        logic [15:0]  sel;
        logic [127:0] dat;
        int           waits;
        int           errb;
        int           exp_cycles;
        logic         exp_ack;
        logic         exp_err;
        int           exp_nbeats;
        logic [127:0] exp_rdata;
        logic [31:0]  exp_adr0;
        logic [3:0]   exp_sel0;
        logic [31:0]  exp_dat0;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_line_narrower_if #(.DATA_WIDTH(128), .ADDR_WIDTH(32), .SEL_WIDTH(16)) wbs_if ();
    wb_line_narrower_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SEL_WIDTH(4)) wbm_if ();

    wb_line_narrower #(
        .LINE_WIDTH(128),
        .NARROW_WIDTH(32),
        .ADDR_WIDTH(32),
        .ADDR_GRANULARITY(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wbs(wbs_if),
        .wbm(wbm_if)
    );

    int checks = 0;
    int failures = 0;

    // Memory contents: a fixed function of the word address.
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000100) return 32'hA0 + {30'b0, a[3:2]};
        return (a ^ 32'h5A5A_5A5A) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    // Memory responder: ack after wait_cfg stall cycles; on beat err_beat assert err and ack.
    int    wait_cfg;
    int    err_beat;
    int    wait_cnt = 0;
    int    beat_no = 0;
    beat_t beat_log[$];
    logic  mem_term;

    assign mem_term      = wbm_if.stb && (wait_cnt >= wait_cfg);
    assign wbm_if.ack    = mem_term;
    assign wbm_if.err    = mem_term && (beat_no == err_beat);
    assign wbm_if.rty    = 1'b0;
    assign wbm_if.dat_r  = rd_word(wbm_if.adr);

    always @(posedge clk) begin
        if (!wbm_if.stb) begin
            wait_cnt <= 0;
            beat_no  <= 0;
        end else if (mem_term) begin
            beat_log.push_back({wbm_if.adr, wbm_if.sel, wbm_if.dat_w, wbm_if.we});
            wait_cnt <= 0;
            beat_no  <= beat_no + 1;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: which beats a line produces, its latency, and the returned line.
    beat_t exp_beats[$];
    task automatic model_line(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                              input logic [127:0] dat, input int waits, input int errb,
                              output int cyc, output logic ack, output logic err,
                              output logic [127:0] rdata);
        logic [31:0] base;
        beat_t       bt;
        int          n;
        int          used;
        base = adr & ~32'hF;
        n = 0;
        used = 0;
        err = 1'b0;
        rdata = '0;
        exp_beats.delete();
        for (int b = 0; b < 4; b++) begin
            if (sel[4*b +: 4] != 4'h0 && !err) begin
                bt.adr = base + 32'(4 * b);
                bt.sel = sel[4*b +: 4];
                bt.dat = dat[32*b +: 32];
                bt.we  = we;
                exp_beats.push_back(bt);
                used += 1 + waits;
                if (n == errb) err = 1'b1;
                else if (!we) rdata[32*b +: 32] = rd_word(bt.adr);
                n++;
            end
        end
        cyc = 1 + used;
        ack = !err;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                             input logic [127:0] dat);
        wbs_if.cyc   = 1'b1;
        wbs_if.stb   = 1'b1;
        wbs_if.we    = we;
        wbs_if.adr   = adr;
        wbs_if.sel   = sel;
        wbs_if.dat_w = dat;
    endtask

    task automatic drop_req();
        wbs_if.cyc = 1'b0;
        wbs_if.stb = 1'b0;
        wbs_if.we  = 1'b0;
    endtask

    // Issues one line; cycles = cycle of the termination pulse (0 on timeout).
    task automatic run_line(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                            input logic [127:0] dat, input int waits, input int errb,
                            output int cycles, output logic gack, output logic gerr,
                            output logic [127:0] rdata, output logic clean);
        wait_cfg = waits;
        err_beat = errb;
        cycles = 0;
        gack = 1'b0;
        gerr = 1'b0;
        rdata = '0;
        @(negedge clk);
        drive_req(we, adr, sel, dat);
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (wbs_if.ack || wbs_if.err) begin
                cycles = c;
                gack = wbs_if.ack;
                gerr = wbs_if.err;
                rdata = wbs_if.dat_r;
                break;
            end
        end
        drop_req();
        @(negedge clk);
        clean = !wbs_if.ack && !wbs_if.err && (wbs_if.dat_r === rdata);
    endtask

    task automatic run_and_check(input string name, input logic we, input logic [31:0] adr,
                                 input logic [15:0] sel, input logic [127:0] dat,
                                 input int waits, input int errb);
        int           ecyc, gcyc, base0, nb;
        logic         eack, eerr, gack, gerr, clean;
        logic [127:0] erd, grd;
        model_line(we, adr, sel, dat, waits, errb, ecyc, eack, eerr, erd);
        base0 = beat_log.size();
        run_line(we, adr, sel, dat, waits, errb, gcyc, gack, gerr, grd, clean);
        nb = beat_log.size() - base0;
        check($sformatf("%s cycles", name), 128'(gcyc), 128'(ecyc));
        check($sformatf("%s ack", name), {127'b0, gack}, {127'b0, eack});
        check($sformatf("%s err", name), {127'b0, gerr}, {127'b0, eerr});
        check($sformatf("%s rdata", name), grd, erd);
        check($sformatf("%s single-pulse/hold", name), {127'b0, clean}, 128'd1);
        check($sformatf("%s nbeats", name), 128'(nb), 128'(exp_beats.size()));
        for (int i = 0; i < nb && i < exp_beats.size(); i++) begin
            check($sformatf("%s beat%0d", name, i), 128'(beat_log[base0+i]),
                  128'(exp_beats[i]));
        end
    endtask

    vec_t vecs[6];

    initial begin
        int           gcyc, base0, nb, seen;
        logic         gack, gerr, clean, we;
        logic [31:0]  adr;
        logic [15:0]  sel;
        logic [127:0] dat, grd;
        int           waits, errb;

        vecs[0] = '{1'b0, 32'h1000, 16'hFFFF, 128'h0, 0, -1, 5, 1'b1, 1'b0, 4,
                    128'h000000A3_000000A2_000000A1_000000A0, 32'h1000, 4'hF, 32'h0};
        vecs[1] = '{1'b1, 32'h2000, 16'h00F0, 128'h33333333_22222222_DEADBEEF_11111111, 0, -1,
                    2, 1'b1, 1'b0, 1, 128'h0, 32'h2004, 4'hF, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 32'h3000, 16'hF00F, 128'h0, 2, -1, 7, 1'b1, 1'b0, 2,
                    {rd_word(32'h300C), 64'h0, rd_word(32'h3000)}, 32'h3000, 4'hF, 32'h0};
        vecs[3] = '{1'b0, 32'h4000, 16'hFFFF, 128'h0, 0, 1, 3, 1'b0, 1'b1, 2,
                    {96'h0, rd_word(32'h4000)}, 32'h4000, 4'hF, 32'h0};
        vecs[4] = '{1'b1, 32'h5000, 16'h0000, 128'hCAFE, 0, -1, 1, 1'b1, 1'b0, 0,
                    128'h0, 32'h0, 4'h0, 32'h0};
        vecs[5] = '{1'b1, 32'h601B, 16'h0300, 128'h44444444_87654321_22222222_11111111, 1, -1,
                    3, 1'b1, 1'b0, 1, 128'h0, 32'h6018, 4'h3, 32'h87654321};

        rst = 1'b1;
        wait_cfg = 0;
        err_beat = -1;
        drive_req(1'b0, 32'h0, 16'h0, 128'h0);
        drop_req();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset wbs_ack", {127'b0, wbs_if.ack}, 128'd0);
        check("reset wbs_err", {127'b0, wbs_if.err}, 128'd0);
        check("reset wbs_dat", wbs_if.dat_r, 128'd0);
        check("reset wbm_stb", {127'b0, wbm_if.stb}, 128'd0);
        check("reset wbm_cyc", {127'b0, wbm_if.cyc}, 128'd0);
        check("reset wbm_we", {127'b0, wbm_if.we}, 128'd0);
        check("reset wbm_sel", 128'(wbm_if.sel), 128'd0);
        check("reset wbm_adr", 128'(wbm_if.adr), 128'd0);
        check("reset wbm_dat", 128'(wbm_if.dat_w), 128'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            base0 = beat_log.size();
            run_line(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].waits,
                     vecs[i].errb, gcyc, gack, gerr, grd, clean);
            nb = beat_log.size() - base0;
            check($sformatf("vec%0d cycles", i), 128'(gcyc), 128'(vecs[i].exp_cycles));
            check($sformatf("vec%0d ack", i), {127'b0, gack}, {127'b0, vecs[i].exp_ack});
            check($sformatf("vec%0d err", i), {127'b0, gerr}, {127'b0, vecs[i].exp_err});
            check($sformatf("vec%0d rdata", i), grd, vecs[i].exp_rdata);
            check($sformatf("vec%0d single-pulse/hold", i), {127'b0, clean}, 128'd1);
            check($sformatf("vec%0d nbeats", i), 128'(nb), 128'(vecs[i].exp_nbeats));
            if (nb > 0 && vecs[i].exp_nbeats > 0) begin
                check($sformatf("vec%0d beat0", i), 128'(beat_log[base0]),
                      128'({vecs[i].exp_adr0, vecs[i].exp_sel0, vecs[i].exp_dat0, vecs[i].we}));
            end
        end

        // Line-side abort during beat 1.
        wait_cfg = 1;
        err_beat = -1;
        @(negedge clk);
        drive_req(1'b0, 32'h6000, 16'hFFFF, 128'h0);
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("abort in beat1", 128'({wbm_if.stb, wbm_if.adr}), 128'({1'b1, 32'h6004}));
        drop_req();
        @(negedge clk);
        check("abort wbm_cyc dropped", 128'({wbm_if.cyc, wbm_if.stb}), 128'd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (wbs_if.ack || wbs_if.err) seen++;
        end
        check("abort no termination", 128'(seen), 128'd0);
        run_and_check("after-abort read", 1'b0, 32'h6000, 16'hFFFF, 128'h0, 0, -1);

        // Reset during beat 2 of a write.
        wait_cfg = 0;
        err_beat = -1;
        @(negedge clk);
        drive_req(1'b1, 32'h7000, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom});
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("reset-mid in beat2", 128'({wbm_if.stb, wbm_if.adr}), 128'({1'b1, 32'h7008}));
        rst = 1'b1;
        drop_req();
        @(negedge clk);
        check("reset-mid wbm zero", 128'({wbm_if.stb, wbm_if.cyc, wbm_if.we, wbm_if.sel,
                                           wbm_if.adr, wbm_if.dat_w}), 128'd0);
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (wbs_if.ack || wbs_if.err) seen++;
        end
        check("reset-mid no termination", 128'(seen), 128'd0);
        run_and_check("after-reset write", 1'b1, 32'h7000, 16'h0FF0,
                      128'h01234567_89ABCDEF_FEDCBA98_76543210, 1, -1);

        for (int i = 0; i < 40; i++) begin
            we  = 1'($urandom_range(0, 1));
            adr = $urandom;
            sel = 16'($urandom);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 2) == 0) sel[4*b +: 4] = 4'h0;
            end
            if ($urandom_range(0, 7) == 0) sel = 16'h0;
            dat   = {$urandom, $urandom, $urandom, $urandom};
            waits = int'($urandom_range(0, 2));
            errb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_and_check($sformatf("rand%0d", i), we, adr, sel, dat, waits, errb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_line_narrower.md
# wb_line_narrower

Wishbone B4 classic width adapter between the cache controller's line-wide bus master and the narrower external memory. It accepts one full cache-line request (read or byte-masked write) on its slave port and issues the required sequence of narrow single-beat transactions on its master port. For reads it assembles the returned beats into one line; for writes it scatters the line. It then returns a single ack (or err) to the line-side master. Beats whose byte-select slice is all zero are skipped, so single-word write-throughs cost one narrow beat.

## Interface
- LINE_WIDTH, 128, line-side data width (bits)
- NARROW_WIDTH, 32, memory-side data width; LINE_WIDTH/NARROW_WIDTH = BEATS, must be a power of two ≥ 2
- ADDR_WIDTH, 32, byte-address width on both sides
- ADDR_GRANULARITY, 8, bits per address unit; sel width = data width / ADDR_GRANULARITY
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wbs_adr_i  in  ADDR_WIDTH  line address; low log2(LINE_WIDTH/ADDR_GRANULARITY) bits ignored
- wbs_dat_i  in  LINE_WIDTH  write line
- wbs_dat_o  out  LINE_WIDTH  assembled read line
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  LINE_WIDTH/ADDR_GRANULARITY  byte selects
- wbs_stb_i, wbs_cyc_i  in  1  strobe / cycle
- wbs_ack_o, wbs_err_o  out  1  one-cycle termination pulses
- wbs_rty_o  out  1  tied 0
- wbm_adr_o  out  ADDR_WIDTH  narrow beat address
- wbm_dat_o  out  NARROW_WIDTH  write beat data
- wbm_dat_i  in  NARROW_WIDTH  read beat data
- wbm_we_o  out  1; wbm_sel_o  out  NARROW_WIDTH/ADDR_GRANULARITY
- wbm_stb_o, wbm_cyc_o  out  1
- wbm_ack_i, wbm_err_i  in  1

## Operation
- FSM states: IDLE, BEAT, RESP.
- IDLE: when wbs_cyc_i & wbs_stb_i, latch adr (line-aligned), dat, sel, we. Clear the assembly register to zero. Select k = lowest beat with a nonzero sel slice.
  - If every sel slice is zero, go to RESP.
  - Otherwise go to BEAT.
- BEAT k drives:
  - wbm_adr_o = line_base + k·(NARROW_WIDTH/ADDR_GRANULARITY)
  - wbm_sel_o = sel[k·NS +: NS]
  - wbm_dat_o = dat[k·NARROW_WIDTH +: NARROW_WIDTH]
  - wbm_we_o = latched we
  - wbm_stb_o = wbm_cyc_o = 1
- On wbm_ack_i in BEAT:
  - For a read, store wbm_dat_i into assembly slice k.
  - Advance to the next higher beat with a nonzero sel. If none remains, go to RESP (ok).
- On wbm_err_i in BEAT: abort the remaining beats and go to RESP (err). If ack and err are both high, err wins.
- RESP: pulse wbs_ack_o (or wbs_err_o) for exactly one cycle, then go to IDLE.
  - wbs_dat_o is the assembly register: skipped beats read as zero, writes return zero.
  - wbs_dat_o holds its value until the next accept.
- Line-side abort: wbs_cyc_i low while in BEAT → drop wbm_stb_o/wbm_cyc_o at the next edge and go to IDLE with no termination. A late wbm_ack_i is ignored.
- Beats are issued strictly in ascending order; there is never more than one narrow transaction outstanding.

## Timing
- Reset: state IDLE. Outputs wbs_ack_o = wbs_err_o = 0, wbs_dat_o = 0, wbm_stb_o = wbm_cyc_o = wbm_we_o = 0, wbm_sel_o = 0, wbm_adr_o = 0, wbm_dat_o = 0.
- All outputs are registered; no combinational path exists from wbs_* inputs to wbm_* outputs.
- Request seen in IDLE at edge 0 → wbm_stb_o high from cycle 1.
- wbm_stb_o/wbm_cyc_o stay continuously high across consecutive beats. The address, sel and data change on the edge that samples wbm_ack_i.
- With zero-wait memory (ack in the first stb cycle), n active beats: wbs_ack_o is high in cycle n+1.
  - Full 4-beat read: ack in cycle 5.
  - Single-word write: ack in cycle 2.
  - All-zero sel: ack in cycle 1.
- Each memory wait state adds one cycle to the beat it stalls.
- After RESP, IDLE accepts a new request no earlier than the cycle after the ack pulse. The master must have dropped stb on the ack edge, or it is treated as a new request.
- rst high at any edge → IDLE and reset outputs at that edge. An in-flight line produces no ack or err.

## Test plan
- Read at line 0x1000, sel all ones, zero-wait memory returning 0xA0,0xA1,0xA2,0xA3 → wbm_adr_o 0x1000/0x1004/0x1008/0x100C; wbs_dat_o = {0xA3,0xA2,0xA1,0xA0}; wbs_ack_o single pulse in cycle 5.
- Write at line 0x2000, sel 0x00F0, data word1 = 0xDEADBEEF → exactly one beat with adr 0x2004, sel 0xF, dat 0xDEADBEEF, we 1; ack in cycle 2.
- Read with sel 0xF00F, memory inserting 2 wait states per beat → only beats 0 and 3 issued; wbs_dat_o[95:32] = 0; ack in cycle 7.
- 4-beat read, wbm_err_i on beat 1 → beats 2 and 3 never issued; wbs_err_o one pulse; wbs_ack_o stays 0.
- wbs_cyc_i dropped during beat 1 → wbm_cyc_o low next cycle; no ack/err; a following read completes normally.
- rst asserted during beat 2 of a write → all wbm_* zero at that edge; no ack; the next request completes normally.
